hog_pixel_feeder: RTL and testbench

- Pixel-side responder for the HOG request/ready interface.
- Packs a serial camera pixel stream (one PIX_W pixel per beat) into PIX_N-pixel words and buffers them in a 2-word FIFO.
- Delivers one word per `request` pulse from the HOG core, with a one-cycle `ready` strobe.
- Sits between the camera capture front end and the `i_data`/`ready`/`request` pins of the HOG top level.

---
 rtl/hog_pixel_feeder.sv | 194 +++++++++++++++++++
 tb/tb_hog_pixel_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hog_pixel_feeder.sv
// Packs serial pixels into PIX_N-pixel words, buffers two, returns one per HOG request with ready 1 cycle later.
// s_ready drops only when the last lane waits on a full FIFO with no pop; HOG_FEED_MSB_FIRST_EN packs first pixel into the MSB lane.

module hog_pixel_feeder_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_vld,
  output logic [DW-1:0] pop_dat,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;

  // When full, a same-cycle push lands on the slot being popped; the pop has already read it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, push_vld} - {1'b0, pop_vld};
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_vld) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
endmodule

module hog_pixel_feeder #(
  parameter int PIX_W = 8,
  parameter int PIX_N = 96,
  parameter int WPF   = 3200,
  parameter int WC_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       s_data,
  input  logic                   s_valid,
  input  logic                   s_sof,
  output logic                   s_ready,
  input  logic                   request,
  output logic                   ready,
  output logic [PIX_W*PIX_N-1:0] o_data,
  output logic                   frame_end,
  output logic                   err
);
  localparam int PC_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam int DW   = PIX_W * PIX_N;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0]   word_q, word_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   o_data_q, o_data_d;
  logic            err_q, err_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;

  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [DW-1:0]   fifo_dout;
  logic            can_pop, req_drop;
  logic            pix_acc, sof_acc, last_pix;
  logic [PC_W-1:0] slot, lane;

  hog_pixel_feeder_fifo #(.DW(DW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (fifo_push),
    .push_dat (word_d),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // No pop in the strobe cycle keeps ready from going high on back-to-back cycles.
  assign can_pop = !fifo_empty && !ready_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (request && !can_pop) state_d = S_WAIT;
      S_WAIT:  if (can_pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    req_drop = 1'b0;
    case (state_q)
      S_IDLE: fifo_pop = request && can_pop;
      S_WAIT: begin
        fifo_pop = can_pop;
        req_drop = request;
      end
      default: ;
    endcase
  end

  assign last_pix  = (pcnt_q == PC_W'(PIX_N - 1));
  assign s_ready   = !(last_pix && fifo_full && !fifo_pop);
  assign pix_acc   = s_valid && s_ready;
  assign sof_acc   = pix_acc && s_sof;
  assign fifo_push = pix_acc && !s_sof && last_pix;
  assign slot      = sof_acc ? '0 : pcnt_q;

`ifdef HOG_FEED_MSB_FIRST_EN
  assign lane = PC_W'(PIX_N - 1) - slot;
`else
  assign lane = slot;
`endif

  always_comb begin
    word_d = word_q;
    pcnt_d = pcnt_q;
    if (pix_acc) begin
      word_d[lane*PIX_W +: PIX_W] = s_data;
      if (s_sof)         pcnt_d = PC_W'(1);
      else if (last_pix) pcnt_d = '0;
      else               pcnt_d = pcnt_q + PC_W'(1);
    end
  end

  always_comb begin
    ready_d  = fifo_pop;
    o_data_d = fifo_pop ? fifo_dout : o_data_q;
    err_d    = err_q | (sof_acc && (pcnt_q != '0)) | req_drop;
    wcnt_d   = wcnt_q;
    if (ready_q) begin
      wcnt_d = (wcnt_q == WC_W'(WPF - 1)) ? '0 : wcnt_q + WC_W'(1);
    end
    if (sof_acc) begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (!rst) begin
      pcnt_q   <= '0;
      ready_q  <= 1'b0;
      o_data_q <= '0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      ready_q  <= ready_d;
      o_data_q <= o_data_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign ready     = ready_q;
  assign o_data    = o_data_q;
  assign err       = err_q;
  assign frame_end = ready_q && (wcnt_q == WC_W'(WPF - 1));
endmodule

// File: tb/tb_hog_pixel_feeder.sv
// Directed bench for hog_pixel_feeder with a queue scoreboard; WPF shrunk to 5 so frame wraps stay short.
module tb_hog_pixel_feeder;
  localparam int PW  = 8;
  localparam int PN  = 96;
  localparam int DW  = PW * PN;
  localparam int WPF = 5;
  localparam int WCW = 3;

  typedef struct {
    logic [DW-1:0] word;
    logic          fe;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] s_data;
  logic          s_valid, s_sof, s_ready;
  logic          request, ready, frame_end, err;
  logic [DW-1:0] o_data;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  int   pushes  = 0;
  logic prev_ready = 1'b0;

  hog_pixel_feeder #(.PIX_W(PW), .PIX_N(PN), .WPF(WPF), .WC_W(WCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_sof     (s_sof),
    .s_ready   (s_ready),
    .request   (request),
    .ready     (ready),
    .o_data    (o_data),
    .frame_end (frame_end),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [7:0] base);
    logic [DW-1:0] w;
    int lane;
    w = '0;
    for (int k = 0; k < PN; k++) begin
`ifdef HOG_FEED_MSB_FIRST_EN
      lane = PN - 1 - k;
`else
      lane = k;
`endif
      w[lane*PW +: PW] = base + 8'(k);
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops the next expected word and frame_end flag.
  always @(negedge clk) begin
    if (rst) begin
      if (ready) begin
        exp_t e;
        strobes++;
        checks++;
        if (prev_ready) begin
          errors++;
          $display("FAIL ready_back_to_back at %0t", $time);
        end
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready at %0t", $time);
        end else begin
          e = q.pop_front();
          checks++;
          if (o_data !== e.word) begin
            errors++;
            $display("FAIL o_data got %h expected %h", o_data, e.word);
          end
          checks++;
          if (frame_end !== e.fe) begin
            errors++;
            $display("FAIL frame_end got %0b expected %0b", frame_end, e.fe);
          end
        end
      end else if (frame_end) begin
        checks++;
        errors++;
        $display("FAIL frame_end_without_ready at %0t", $time);
      end
      prev_ready = ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic sof);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) chk("pix_accept_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_part(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) send_pix(base + 8'(k), 1'b0);
  endtask

  task automatic push_exp(input logic [7:0] base, input logic fe);
    exp_t e;
    e.word = mk(base);
    e.fe   = fe;
    q.push_back(e);
    pushes++;
  endtask

  task automatic send_word(input logic [7:0] base, input logic sof, input logic fe);
    for (int k = 0; k < PN; k++) send_pix(base + 8'(k), sof && (k == 0));
    push_exp(base, fe);
  endtask

  task automatic req_pulse();
    request = 1'b1;
    tick();
    request = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(q.size()), 32'd0);
  endtask

  // Called in the cycle after the last pixel accept; the strobe must come in that cycle or the next.
  task automatic win_check(input string name);
    int seen = 0;
    int first = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) begin
        seen++;
        if (first < 0) first = i;
      end
      tick();
    end
    chk({name, "_strobes"}, 32'(seen), 32'd1);
    chk({name, "_by_u2"}, 32'(first >= 0 && first <= 1), 32'd1);
  endtask

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_sof   = 1'b0;
    request = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_frame_end", 32'(frame_end), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_o_data_zero", 32'(o_data == '0), 32'd1);
    tick();
    rst = 1'b1;

    // Single word with SOF, request 5 cycles later.
    send_word(8'h00, 1'b1, 1'b0);
    repeat (5) tick();
    request = 1'b1;
    @(negedge clk);
    chk("t1_no_ready_in_req_cycle", 32'(ready), 32'd0);
    tick();
    request = 1'b0;
    @(negedge clk);
    chk("t1_ready_lat1", 32'(ready), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_ready_one_cycle", 32'(ready), 32'd0);
    tick();
    repeat (3) tick();
    chk("t1_o_data_hold", 32'(o_data == mk(8'h00)), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // Request with the FIFO empty, then the data.
    req_pulse();
    @(negedge clk);
    chk("t2_no_ready_empty", 32'(ready), 32'd0);
    tick();
    send_word(8'h10, 1'b0, 1'b0);
    win_check("t2");

    // Three words with no requests; the last pixel stalls until a pop.
    send_word(8'h20, 1'b0, 1'b0);
    send_word(8'h40, 1'b0, 1'b0);
    send_part(8'h60, PN - 1);
    push_exp(8'h60, 1'b1);
    s_valid = 1'b1;
    s_data  = 8'h60 + 8'(PN - 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_s_ready_low", 32'(s_ready), 32'd0);
      tick();
    end
    request = 1'b1;
    @(negedge clk);
    chk("t3_s_ready_release", 32'(s_ready), 32'd1);
    tick();
    request = 1'b0;
    s_valid = 1'b0;
    repeat (3) tick();
    req_pulse();
    repeat (3) tick();
    req_pulse();
    drain("t3_drain");

    // Double request while waiting: one error, one strobe.
    chk("t4_err_before", 32'(err), 32'd0);
    req_pulse();
    repeat (2) tick();
    req_pulse();
    @(negedge clk);
    chk("t4_err_set", 32'(err), 32'd1);
    chk("t4_no_ready", 32'(ready), 32'd0);
    tick();
    send_word(8'hC0, 1'b0, 1'b0);
    win_check("t4");

    // Reset after 50 pixels of a word.
    send_part(8'h33, 50);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready", 32'(ready), 32'd0);
    chk("t5_frame_end", 32'(frame_end), 32'd0);
    chk("t5_err_cleared", 32'(err), 32'd0);
    chk("t5_s_ready", 32'(s_ready), 32'd1);
    chk("t5_o_data_zero", 32'(o_data == '0), 32'd1);
    tick();
    send_word(8'h50, 1'b0, 1'b0);
    req_pulse();
    drain("t5_drain");

    // SOF at pixel 40 of a word.
    send_part(8'h80, 40);
    send_word(8'hA0, 1'b1, 1'b0);
    chk("t6_err_set", 32'(err), 32'd1);
    req_pulse();
    drain("t6_drain");
    repeat (4) tick();
    chk("t6_err_sticky", 32'(err), 32'd1);

    // Two full frames; frame_end on the 5th and 10th strobes.
    for (int k = 0; k < 2 * WPF; k++) begin
      send_word(8'(k * 16 + 5), k == 0, (k == WPF - 1) || (k == 2 * WPF - 1));
      req_pulse();
      drain("t7_drain");
    end

    repeat (4) tick();
    chk("strobe_total", 32'(strobes), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
